// File: rtl/lsu_mem_master.sv
// Load/store initiator between the MEM stage and a 64-bit byte-addressed data memory.
// Sub-doubleword stores are done as an aligned read-modify-write of the containing dword.
module lsu_mem_master #(
   parameter int unsigned MEM_BYTES = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [63:0] mem_rdata
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

   state_e      state_q, state_d;
   logic [63:0] addr_q, wdata_q, rbuf_q;
   logic [2:0]  funct3_q;
   logic        write_q, err_q;

   logic        accept;
   logic        illegal, misaligned, out_of_range, req_err;
   logic [63:0] req_base;

   logic [2:0]  lane;
   logic [63:0] base;
   logic [7:0]  size_mask, byte_mask;
   logic [63:0] wdata_shifted, merged, store_data;
   logic [63:0] rbuf_shifted, load_data;

   assign accept = req_valid && (state_q == StIdle);

   // Request checks operate on the raw inputs so the error is known at acceptance.
   always_comb begin
      illegal    = (req_funct3 == 3'b111) || (req_write && req_funct3[2]);
      misaligned = 1'b0;
      case (req_funct3[1:0])
         2'b01:   misaligned = req_addr[0];
         2'b10:   misaligned = (req_addr[1:0] != 2'b00);
         2'b11:   misaligned = (req_addr[2:0] != 3'b000);
         default: misaligned = 1'b0;
      endcase
      req_base     = {req_addr[63:3], 3'b000};
      out_of_range = req_base > 64'(MEM_BYTES - 8);
      req_err      = illegal || misaligned || out_of_range;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               if (req_err)                                 state_d = StResp;
               else if (req_write && req_funct3[1:0] == 2'b11) state_d = StWrite;
               else                                         state_d = StRead;
            end
         end
         StRead:  state_d = write_q ? StWrite : StResp;
         StWrite: state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         wdata_q  <= '0;
         rbuf_q   <= '0;
         funct3_q <= '0;
         write_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            write_q  <= req_write;
            err_q    <= req_err;
         end
         if (state_q == StRead) rbuf_q <= mem_rdata;
      end
   end

   assign lane = addr_q[2:0];
   assign base = {addr_q[63:3], 3'b000};

   always_comb begin
      case (funct3_q[1:0])
         2'b00:   size_mask = 8'h01;
         2'b01:   size_mask = 8'h03;
         2'b10:   size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
      byte_mask     = size_mask << lane;
      wdata_shifted = wdata_q << {lane, 3'b000};
      merged        = '0;
      for (int i = 0; i < 8; i++) begin
         merged[i*8 +: 8] = byte_mask[i] ? wdata_shifted[i*8 +: 8] : rbuf_q[i*8 +: 8];
      end
      store_data = (funct3_q[1:0] == 2'b11) ? wdata_q : merged;
   end

   always_comb begin
      rbuf_shifted = rbuf_q >> {lane, 3'b000};
      case (funct3_q)
         3'b000:  load_data = {{56{rbuf_shifted[7]}},  rbuf_shifted[7:0]};
         3'b001:  load_data = {{48{rbuf_shifted[15]}}, rbuf_shifted[15:0]};
         3'b010:  load_data = {{32{rbuf_shifted[31]}}, rbuf_shifted[31:0]};
         3'b011:  load_data = rbuf_shifted;
         3'b100:  load_data = {56'd0, rbuf_shifted[7:0]};
         3'b101:  load_data = {48'd0, rbuf_shifted[15:0]};
         3'b110:  load_data = {32'd0, rbuf_shifted[31:0]};
         default: load_data = '0;
      endcase
   end

   always_comb begin
      req_ready  = (state_q == StIdle);
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (state_q)
         StRead: begin
            mem_read = 1'b1;
            mem_addr = base;
         end
         StWrite: begin
            // Gating by reset keeps an aborted request from landing in memory.
            mem_write = !reset;
            mem_addr  = base;
            mem_wdata = store_data;
         end
         StResp: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            if (!err_q && !write_q) resp_rdata = load_data;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a behavioural 256-byte data memory.
module tb_lsu_mem_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_write;
   logic        mem_read;
   logic [63:0] mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mem [0:255];

   // Per-cycle samples for cycles T+1..T+4 after acceptance.
   logic        s_rv [1:4];
   logic        s_re [1:4];
   logic        s_mr [1:4];
   logic        s_mw [1:4];
   logic [63:0] s_rd [1:4];
   logic [63:0] s_ma [1:4];
   logic [63:0] s_wd [1:4];
   int          n_mr, n_mw;

   always #5 clk = ~clk;

   lsu_mem_master #(.MEM_BYTES(256)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_write  (mem_write),
      .mem_read   (mem_read),
      .mem_rdata  (mem_rdata)
   );

   always_comb begin
      mem_rdata = '0;
      if (mem_addr < 64'd256) begin
         for (int i = 0; i < 8; i++) mem_rdata[i*8 +: 8] = mem[mem_addr[7:0] + 8'(i)];
      end
   end

   always @(posedge clk) begin
      if (mem_write && mem_addr < 64'd256) begin
         for (int i = 0; i < 8; i++) mem[mem_addr[7:0] + 8'(i)] <= mem_wdata[i*8 +: 8];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic put64(input int a, input logic [63:0] v);
      for (int i = 0; i < 8; i++) mem[a + i] = v[i*8 +: 8];
   endtask

   function automatic logic [63:0] get64(input int a);
      logic [63:0] v;
      for (int i = 0; i < 8; i++) v[i*8 +: 8] = mem[a + i];
      return v;
   endfunction

   task automatic do_req(input logic w, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] d);
      int waited;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
      waited = 0;
      while (!req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) check("accept_timeout", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      n_mr = 0; n_mw = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         s_rv[k] = resp_valid; s_re[k] = resp_err; s_rd[k] = resp_rdata;
         s_mr[k] = mem_read;   s_mw[k] = mem_write; s_ma[k] = mem_addr; s_wd[k] = mem_wdata;
         n_mr += int'(mem_read);
         n_mw += int'(mem_write);
      end
   endtask

   task automatic err_case(input string tag, input logic w, input logic [2:0] f3,
                           input logic [63:0] a);
      do_req(w, f3, a, 64'h0);
      check({tag, "_rv1"}, 64'(s_rv[1]), 64'd1);
      check({tag, "_err1"}, 64'(s_re[1]), 64'd1);
      check({tag, "_memacc"}, 64'(n_mr + n_mw), 64'd0);
   endtask

   initial begin
      logic rdy_seen [0:5];
      logic rv_seen  [0:5];
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
      req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_ready", 64'(req_ready), 64'd1);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_err", 64'(resp_err), 64'd0);
      check("rst_rdata", resp_rdata, 64'd0);
      check("rst_mem_rw", {62'd0, mem_read, mem_write}, 64'd0);
      check("rst_mem_addr", mem_addr, 64'd0);
      check("rst_mem_wdata", mem_wdata, 64'd0);

      // LD at 0
      put64(0, 64'h63);
      do_req(1'b0, 3'b011, 64'h0, 64'h0);
      check("ld0_read_t1", 64'(s_mr[1]), 64'd1);
      check("ld0_read_count", 64'(n_mr), 64'd1);
      check("ld0_addr_t1", s_ma[1], 64'h0);
      check("ld0_rv_t1", 64'(s_rv[1]), 64'd0);
      check("ld0_rv_t2", 64'(s_rv[2]), 64'd1);
      check("ld0_rdata", s_rd[2], 64'h63);
      check("ld0_err", 64'(s_re[2]), 64'd0);
      check("ld0_rv_t3", 64'(s_rv[3]), 64'd0);

      // LB / LBU sign handling
      mem[16] = 8'hF0;
      do_req(1'b0, 3'b000, 64'h10, 64'h0);
      check("lb_rdata", s_rd[2], 64'hFFFF_FFFF_FFFF_FFF0);
      do_req(1'b0, 3'b100, 64'h10, 64'h0);
      check("lbu_rdata", s_rd[2], 64'h0000_0000_0000_00F0);

      // SB read-modify-write
      put64(8, 64'h5F);
      do_req(1'b1, 3'b000, 64'h09, 64'h1122_3344_5566_77AB);
      check("sb_read_t1", 64'(s_mr[1]), 64'd1);
      check("sb_raddr_t1", s_ma[1], 64'h8);
      check("sb_write_t2", 64'(s_mw[2]), 64'd1);
      check("sb_wdata_t2", s_wd[2], 64'h0000_0000_0000_AB5F);
      check("sb_rw_count", 64'(n_mr * 10 + n_mw), 64'd11);
      check("sb_rv_t2", 64'(s_rv[2]), 64'd0);
      check("sb_rv_t3", 64'(s_rv[3]), 64'd1);
      check("sb_rdata_zero", s_rd[3], 64'd0);
      do_req(1'b0, 3'b011, 64'h08, 64'h0);
      check("sb_readback", s_rd[2], 64'h0000_0000_0000_AB5F);

      // SH into lanes 2-3, then signed/unsigned halfword loads
      do_req(1'b1, 3'b001, 64'h12, 64'hFFFF_0000_0000_BEEF);
      check("sh_wdata", s_wd[2], 64'h0000_0000_BEEF_00F0);
      do_req(1'b0, 3'b001, 64'h12, 64'h0);
      check("lh_rdata", s_rd[2], 64'hFFFF_FFFF_FFFF_BEEF);
      do_req(1'b0, 3'b101, 64'h12, 64'h0);
      check("lhu_rdata", s_rd[2], 64'h0000_0000_0000_BEEF);

      // SD is a single write
      do_req(1'b1, 3'b011, 64'h20, 64'h0000_0000_0000_CAFE);
      check("sd_write_t1", 64'(s_mw[1]), 64'd1);
      check("sd_noread", 64'(n_mr), 64'd0);
      check("sd_wdata", s_wd[1], 64'hCAFE);
      check("sd_rv_t2", 64'(s_rv[2]), 64'd1);
      check("sd_mem", get64(32), 64'hCAFE);

      // Rejected requests
      err_case("lw_misalign", 1'b0, 3'b010, 64'h06);
      err_case("ld_oor", 1'b0, 3'b011, 64'h100);
      err_case("f3_111", 1'b0, 3'b111, 64'h0);
      err_case("sbu_illegal", 1'b1, 3'b100, 64'h0);

      // Last legal doubleword
      put64(248, 64'h8877_6655_4433_2211);
      do_req(1'b0, 3'b011, 64'hF8, 64'h0);
      check("ld_f8_err", 64'(s_re[2]), 64'd0);
      check("ld_f8_rdata", s_rd[2], 64'h8877_6655_4433_2211);

      // Reset during the WRITE cycle of an SD
      put64(24, 64'hDEAD);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b011;
      req_addr = 64'h18; req_wdata = 64'h1234;
      @(posedge clk);
      #1 req_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      check("rstw_write_gated", 64'(mem_write), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rstw_ready", 64'(req_ready), 64'd1);
      check("rstw_no_resp", 64'(resp_valid), 64'd0);
      check("rstw_mem", get64(24), 64'hDEAD);

      // Back-to-back loads with req_valid held high
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b011; req_addr = 64'h0;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         rdy_seen[k] = req_ready;
         rv_seen[k]  = resp_valid;
      end
      req_valid = 1'b0;
      check("b2b_ready", {58'd0, rdy_seen[0], rdy_seen[1], rdy_seen[2], rdy_seen[3],
                          rdy_seen[4], rdy_seen[5]}, 64'b100100);
      check("b2b_resp", {58'd0, rv_seen[0], rv_seen[1], rv_seen[2], rv_seen[3],
                         rv_seen[4], rv_seen[5]}, 64'b001001);
      repeat (3) @(negedge clk);
      check("end_idle", 64'(req_ready), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator between the pipeline MEM stage and the byte-addressed 64-bit data memory (combinational read, write on rising clk).
- Accepts one load/store request at a time and drives the data memory's address, write data, MemWrite and MemRead.
- Performs byte, half and word stores as an aligned doubleword read-modify-write, and extracts/extends load data.
- Reports misaligned, out-of-range and illegal accesses without touching memory.

Parameters:
MEM_BYTES, 256, size of the data memory in bytes; legal doubleword bases are 0 to MEM_BYTES-8.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (IDLE only)
req_write  input  1  1=store, 0=load
req_funct3  input  3  RISC-V width/sign code
req_addr  input  64  byte address
req_wdata  input  64  store data; low bytes used for sub-doubleword stores
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  64  load result, valid when resp_valid and load; 0 otherwise
resp_err  output  1  with resp_valid: access rejected
mem_addr  output  64  to data memory Mem_Addr
mem_wdata  output  64  to data memory Write_Data
mem_write  output  1  to data memory MemWrite
mem_read  output  1  to data memory MemRead
mem_rdata  input  64  from data memory Read_Data, same-cycle

Behaviour:
- Reset: state IDLE. Outputs: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0.
- Request handshake:
  - A request is accepted on the rising edge where req_valid and req_ready are both 1.
  - addr, funct3, write and wdata are registered on acceptance.
  - req_ready=1 only in IDLE.
- Address fields: base = addr with bits [2:0] cleared; lane = addr[2:0].
- funct3 encoding:
  - 000 B, 001 H, 010 W, 011 D.
  - 100 BU, 101 HU, 110 WU: loads only.
  - 111, and stores with funct3[2]=1, are illegal.
- Error check at acceptance, in priority order:
  - illegal funct3;
  - misaligned: H with lane[0]≠0, W with lane[1:0]≠0, D with lane≠0;
  - out of range: base > MEM_BYTES-8.
  - On any error: next state RESP with err=1. No mem_read or mem_write is ever asserted for that request.
- States: IDLE, READ, WRITE, RESP.
  - IDLE -> READ: legal load, or store of B/H/W.
  - IDLE -> WRITE: legal D store.
  - IDLE -> RESP: error.
  - READ: mem_read=1, mem_addr=base. Capture mem_rdata into rbuf at end of cycle. Load -> RESP; store -> WRITE.
  - WRITE: mem_write=1, mem_addr=base, mem_wdata as follows, then -> RESP.
    - D store: mem_wdata=req_wdata.
    - B/H/W store: mem_wdata=rbuf with bytes lane..lane+size-1 replaced by req_wdata bytes 0..size-1, little-endian.
  - RESP: resp_valid=1 for exactly one cycle, then -> IDLE. No backpressure.
- Load data: take size bytes of rbuf starting at lane, right-justify, then:
  - B/H/W: sign-extend to 64 bits;
  - BU/HU/WU: zero-extend;
  - D: passthrough.
- Latency from accept edge T (cycle T+1 is the first cycle after acceptance):
  - load: resp_valid in cycle T+2;
  - D store: write in cycle T+1, resp in T+2;
  - B/H/W store: read T+1, write T+2, resp T+3;
  - error: resp T+1.
- Memory-side outputs are decoded from state. mem_addr and mem_wdata are 0 in IDLE and RESP.
- mem_write is gated by !reset, so reset asserted during WRITE prevents the write on that edge.
- Reset in any state: next cycle is IDLE and the pending request is discarded with no response.
- req_valid while not ready is ignored. The requester holds it until accepted.

Test Plan:
- Preload dword@0=0x0000_0000_0000_0063, LD addr 0x0 -> mem_read in T+1 only; resp_valid in T+2 with rdata=0x63, err=0.
- Preload byte@0x10=0xF0:
  - LB 0x10 -> rdata=0xFFFF_FFFF_FFFF_FFF0;
  - LBU 0x10 -> rdata=0x0000_0000_0000_00F0.
- Preload dword@8=0x5F, SB addr 0x09 wdata 0x...AB:
  - one read cycle, then one write cycle with mem_wdata=0x0000_0000_0000_AB5F, resp T+3;
  - a following LD 0x08 returns 0xAB5F.
- Error cases, each giving resp_err=1 at T+1 with mem_read=mem_write=0 throughout:
  - LW addr 0x06;
  - LD addr 0x100 with MEM_BYTES=256;
  - funct3=111.
- LD 0xF8 -> legal, err=0.
- Assert reset during the WRITE cycle of SD addr 0x18 wdata 0x1234 -> memory unchanged, no resp_valid, req_ready=1 next cycle.
- Back-to-back: req_valid held high across two loads -> second accepted only in IDLE after the first RESP; req_ready low in all other cycles.
